button_pio_irq: RTL

Debounced pushbutton input port with edge capture and interrupt, exposed to the HPS as an Avalon-MM slave. It is the input-direction counterpart of the LED PIO. It sits in the 100 MHz FPGA fabric domain, takes raw active-low board buttons, and raises a level interrupt to the HPS on masked press or release events.

---
 rtl/button_pio_irq_if.sv | 18 +
 rtl/button_pio_irq.sv | 101 ++++++++++
 2 files changed

// File: rtl/button_pio_irq_if.sv
// Avalon-MM slave bus for the pushbutton PIO: word address, strobes, 32-bit data.
interface button_pio_irq_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/button_pio_irq.sv
// Debounced active-low pushbutton PIO with per-bit press/release edge capture
// and a masked level interrupt, behind an Avalon-MM slave with read latency 1.

module button_pio_lane #(
  parameter int unsigned TIMEOUT       = 10000,
  parameter int unsigned TIMEOUT_WIDTH = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic stable
);
  logic [1:0]               sync;
  logic [TIMEOUT_WIDTH-1:0] cnt;
  logic                     pressed;

  // Synchronizer resets to "released" so nothing looks pressed out of reset.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], button};

  assign pressed = ~sync[1];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (pressed == stable) begin
      cnt <= '0;
    end else if (cnt == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
      stable <= pressed;
      cnt    <= '0;
    end else begin
      cnt <= cnt + TIMEOUT_WIDTH'(1);
    end
endmodule

module button_pio_irq #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned TIMEOUT       = 10000,
  parameter int unsigned TIMEOUT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      button_in,
  button_pio_irq_if.slave       avs,
  output logic                  irq
);
  localparam logic [1:0] A_DATA = 2'd0, A_MASK = 2'd1, A_CAP = 2'd2, A_SEL = 2'd3;

  logic [WIDTH-1:0] stable, stable_d;
  logic [WIDTH-1:0] irq_mask, edge_cap, edge_sel;
  logic [WIDTH-1:0] evt, clr, wdata, rd_mux;

  button_pio_lane #(
    .TIMEOUT       (TIMEOUT),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_lane [WIDTH-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .button  (button_in),
    .stable  (stable)
  );

  assign wdata = avs.avs_writedata[WIDTH-1:0];

  // Per-bit select: 0 captures the press (rising stable), 1 the release.
  assign evt = (stable & ~stable_d & ~edge_sel) | (~stable & stable_d & edge_sel);
  assign clr = (avs.avs_write && avs.avs_address == A_CAP) ? wdata : '0;

  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      A_DATA: rd_mux = stable;
      A_MASK: rd_mux = irq_mask;
      A_CAP:  rd_mux = edge_cap;
      A_SEL:  rd_mux = edge_sel;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stable_d         <= '0;
      irq_mask         <= '0;
      edge_sel         <= '0;
      edge_cap         <= '0;
      irq              <= 1'b0;
      avs.avs_readdata <= '0;
    end else begin
      stable_d <= stable;
      // Set wins over a same-cycle W1C clear.
      edge_cap <= (edge_cap & ~clr) | evt;
      irq      <= |(edge_cap & irq_mask);
      if (avs.avs_read) avs.avs_readdata <= 32'(rd_mux);
      if (avs.avs_write) begin
        if (avs.avs_address == A_MASK) irq_mask <= wdata;
        if (avs.avs_address == A_SEL)  edge_sel <= wdata;
      end
    end
endmodule
